// File: rtl/heart_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : heart_rate_meter
// Description : Times qualified heart-pulse intervals, averages the last
//               2^AVG_LOG2 periods, divides into a BPM value, converts it to
//               BCD and drives beat LED, buzzer and sticky rate alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module heart_rate_meter #(
    parameter int CLK_PER_MIN  = 6000,
    parameter int PER_W        = 11,
    parameter int AVG_LOG2     = 2,
    parameter int MIN_PER      = 20,
    parameter int BLINK_CYCLES = 10,
    parameter int LOW_BPM      = 40,
    parameter int HIGH_BPM     = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heart_pulse,
    input  logic       mute,
    input  logic       clear_alarm,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       led,
    output logic       buzzer,
    output logic       alarm_low,
    output logic       alarm_high,
    output logic       no_signal
);

    localparam int DIV_W     = $clog2(CLK_PER_MIN + 1);
    localparam int c_win     = 1 << AVG_LOG2;
    localparam int c_sum_w   = PER_W + AVG_LOG2;
    localparam int c_led_w   = $clog2(BLINK_CYCLES + 1);
    localparam int c_dcnt_w  = $clog2(DIV_W + 1);
    localparam logic [PER_W-1:0] c_cnt_max = {PER_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    logic                r_sync1, r_sync2, r_sync3;
    logic [PER_W-1:0]    r_cnt;
    logic                r_armed;
    logic                r_per_valid;
    logic [PER_W-1:0]    r_period;
    logic [PER_W-1:0]    r_win [c_win];
    logic [c_sum_w-1:0]  r_sum;
    logic                r_win_full;
    div_state_t          r_state;
    logic [PER_W-1:0]    r_divisor;
    logic [DIV_W-1:0]    r_dvd;
    logic [PER_W-1:0]    r_rem;
    logic [DIV_W-1:0]    r_quo;
    logic [c_dcnt_w-1:0] r_dcnt;
    logic [c_led_w-1:0]  r_led_cnt;

    logic                w_beat, w_sat, w_timeout, w_accept;
    logic [c_sum_w-1:0]  w_sum_next;
    logic [PER_W-1:0]    w_avg;
    logic [PER_W:0]      w_trial;
    logic                w_ge;
    logic [PER_W-1:0]    w_diff;
    logic [7:0]          w_q_sat;
    logic [7:0]          w_rem100;
    logic [3:0]          w_hund, w_tens, w_ones;

    // Beat qualification: first cycle the synchronised pulse is seen high
    assign w_beat    = r_sync2 & ~r_sync3;
    assign w_sat     = (r_cnt == c_cnt_max);
    // A saturated counter while armed means the signal has been lost; it
    // takes priority over a beat landing in the same cycle.
    assign w_timeout = r_armed & w_sat;
    assign w_accept  = w_beat & ~w_timeout &
                       (~r_armed | (r_cnt >= PER_W'(MIN_PER)));

    // Running window sum: the first period after arming seeds every slot
    assign w_sum_next = r_win_full
                      ? (r_sum + c_sum_w'(r_period) - c_sum_w'(r_win[c_win-1]))
                      : (c_sum_w'(r_period) << AVG_LOG2);
    assign w_avg      = w_sum_next[c_sum_w-1:AVG_LOG2];

    // One restoring-division step
    assign w_trial = {r_rem, r_dvd[DIV_W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_divisor});
    assign w_diff  = w_trial[PER_W-1:0] - r_divisor;

    // Saturated rate and its BCD digits
    assign w_q_sat  = (r_quo > DIV_W'(255)) ? 8'hFF : r_quo[7:0];
    assign w_hund   = 4'(w_q_sat / 8'd100);
    assign w_rem100 = w_q_sat % 8'd100;
    assign w_tens   = 4'(w_rem100 / 8'd10);
    assign w_ones   = 4'(w_rem100 % 8'd10);

    assign led    = (r_led_cnt != '0);
    assign buzzer = ~mute & (led | alarm_low | alarm_high | no_signal);

    // Two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= heart_pulse;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Period counter, arming and period capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_per_valid <= 1'b0;
            r_period    <= '0;
        end else begin
            r_per_valid <= w_accept & r_armed;
            if (w_accept) begin
                r_cnt    <= PER_W'(1);
                r_period <= r_cnt;
                r_armed  <= 1'b1;
            end else begin
                if (!w_sat)
                    r_cnt <= r_cnt + PER_W'(1);
                if (w_timeout)
                    r_armed <= 1'b0;
            end
        end
    end

    // Averaging window: shift in newest period, oldest falls off the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_win; i++)
                r_win[i] <= '0;
            r_sum      <= '0;
            r_win_full <= 1'b0;
        end else if (w_timeout) begin
            for (int i = 0; i < c_win; i++)
                r_win[i] <= '0;
            r_sum      <= '0;
            r_win_full <= 1'b0;
        end else if (r_per_valid) begin
            if (r_win_full) begin
                for (int i = c_win - 1; i > 0; i--)
                    r_win[i] <= r_win[i-1];
                r_win[0] <= r_period;
            end else begin
                for (int i = 0; i < c_win; i++)
                    r_win[i] <= r_period;
            end
            r_sum      <= w_sum_next;
            r_win_full <= 1'b1;
        end
    end

    // Sequential divider FSM: CLK_PER_MIN / avg, one quotient bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_divisor <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dcnt    <= '0;
        end else if (r_per_valid) begin
            r_divisor <= w_avg;
            r_dvd     <= DIV_W'(CLK_PER_MIN);
            r_rem     <= '0;
            r_quo     <= '0;
            r_dcnt    <= c_dcnt_w'(DIV_W);
            r_state   <= S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem  <= w_ge ? w_diff : w_trial[PER_W-1:0];
                    r_quo  <= {r_quo[DIV_W-2:0], w_ge};
                    r_dvd  <= {r_dvd[DIV_W-2:0], 1'b0};
                    r_dcnt <= r_dcnt - c_dcnt_w'(1);
                    if (r_dcnt == c_dcnt_w'(1))
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result registers, strobe and sticky flags (a set beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm        <= '0;
            hundreds   <= '0;
            tens       <= '0;
            ones       <= '0;
            bpm_valid  <= 1'b0;
            alarm_low  <= 1'b0;
            alarm_high <= 1'b0;
            no_signal  <= 1'b0;
        end else if (r_state == S_DONE) begin
            bpm        <= w_q_sat;
            hundreds   <= w_hund;
            tens       <= w_tens;
            ones       <= w_ones;
            bpm_valid  <= 1'b1;
            no_signal  <= 1'b0;
            alarm_low  <= (w_q_sat < 8'(LOW_BPM))  | (alarm_low  & ~clear_alarm);
            alarm_high <= (w_q_sat > 8'(HIGH_BPM)) | (alarm_high & ~clear_alarm);
        end else begin
            alarm_low  <= alarm_low  & ~clear_alarm;
            alarm_high <= alarm_high & ~clear_alarm;
            if (w_timeout) begin
                bpm       <= '0;
                hundreds  <= '0;
                tens      <= '0;
                ones      <= '0;
                bpm_valid <= 1'b1;
                no_signal <= 1'b1;
            end else begin
                bpm_valid <= 1'b0;
            end
        end
    end

    // Beat LED: retriggerable down-counter loaded on each accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_led_cnt <= '0;
        else if (w_accept)
            r_led_cnt <= c_led_w'(BLINK_CYCLES);
        else if (r_led_cnt != '0)
            r_led_cnt <= r_led_cnt - c_led_w'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_heart_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_heart_rate_meter
// Description : Self-checking bench for heart_rate_meter. A pin-level model
//               (edge times, period differences, window queue, integer
//               division) predicts every output each cycle; directed
//               literals pin the key rates and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heart_rate_meter;

    localparam int CPM    = 6000;
    localparam int MINP   = 20;
    localparam int BLINK  = 10;
    localparam int LOWB   = 40;
    localparam int HIGHB  = 180;
    localparam int SATC   = 2047;
    localparam int LAT    = 16;
    localparam int NWIN   = 4;
    localparam int MAXCYC = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       heart_pulse = 1'b0;
    logic       mute = 1'b0;
    logic       clear_alarm = 1'b0;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic [3:0] ones, tens, hundreds;
    logic       led, buzzer, alarm_low, alarm_high, no_signal;

    heart_rate_meter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .heart_pulse (heart_pulse),
        .mute        (mute),
        .clear_alarm (clear_alarm),
        .bpm         (bpm),
        .bpm_valid   (bpm_valid),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds),
        .led         (led),
        .buzzer      (buzzer),
        .alarm_low   (alarm_low),
        .alarm_high  (alarm_high),
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passed = 0;

    // pin-level record of driven rising edges
    bit pin_rise [MAXCYC];

    // behavioural model state
    typedef struct {
        int at;
        int rate;
        bit to;
    } ev_t;
    ev_t  sched [$];
    int   m_win [$];
    int   m_bpm = 0;
    bit   m_valid = 0;
    bit   m_low = 0, m_high = 0, m_ns = 0, m_armed = 0, clr_prev = 0;
    int   m_last = 0;
    int   m_led_until = -1;

    // observation records
    int   n_strobe = 0;
    int   led_cnt = 0;
    int   seen_q [$];

    logic [25:0] got_v, exp_v;
    bit   e_led, e_buz, set_l, set_h, m_beat;
    int   p, s, a, q;
    ev_t  ev;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Model update, per-cycle comparison and observation, all at negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            sched.delete();
            m_win.delete();
            m_bpm = 0; m_valid = 0; m_low = 0; m_high = 0; m_ns = 0;
            m_armed = 0; m_led_until = -1;
        end else begin
            m_valid = 0;
            set_l = 0;
            set_h = 0;
            if (sched.size() > 0 && sched[0].at == cyc) begin
                ev = sched.pop_front();
                m_valid = 1;
                m_bpm = ev.rate;
                if (ev.to) m_ns = 1;
                else begin
                    m_ns  = 0;
                    set_l = (m_bpm < LOWB);
                    set_h = (m_bpm > HIGHB);
                end
            end
            m_low  = set_l ? 1'b1 : (clr_prev ? 1'b0 : m_low);
            m_high = set_h ? 1'b1 : (clr_prev ? 1'b0 : m_high);
        end

        e_led = (cyc <= m_led_until);
        e_buz = !mute && (e_led || m_low || m_high || m_ns);
        got_v = {bpm, bpm_valid, hundreds, tens, ones, led, buzzer,
                 alarm_low, alarm_high, no_signal};
        exp_v = {8'(m_bpm), m_valid, 4'(m_bpm / 100), 4'((m_bpm / 10) % 10),
                 4'(m_bpm % 10), e_led, e_buz, m_low, m_high, m_ns};
        checks++;
        if (got_v === exp_v) passed++;
        else $display("FAIL cycle %0d outputs: got %h, expected %h", cyc, got_v, exp_v);

        if (bpm_valid === 1'b1) begin
            n_strobe++;
            seen_q.push_back(int'(bpm));
        end
        if (led === 1'b1) led_cnt++;

        // events that happen during this cycle take effect from the next one
        if (rst_n) begin
            m_beat = (cyc >= 2 && cyc - 2 < MAXCYC) ? pin_rise[cyc-2] : 1'b0;
            if (m_armed && (cyc - m_last == SATC)) begin
                sched.push_back('{at: cyc + 1, rate: 0, to: 1'b1});
                m_armed = 0;
                m_win.delete();
            end else if (m_beat && !(m_armed && (cyc - m_last < MINP))) begin
                m_led_until = cyc + BLINK;
                if (m_armed) begin
                    p = cyc - m_last;
                    if (m_win.size() == 0) begin
                        for (int i = 0; i < NWIN; i++) m_win.push_back(p);
                    end else begin
                        void'(m_win.pop_back());
                        m_win.push_front(p);
                    end
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    a = s / NWIN;
                    q = CPM / a;
                    sched.push_back('{at: cyc + LAT, rate: (q > 255) ? 255 : q, to: 1'b0});
                end
                m_armed = 1;
                m_last  = cyc;
            end
        end
        clr_prev = clear_alarm;
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    int last_rise = 0;

    // Raise the pin 'gap' cycles after the previous rise, hold for 3 cycles
    task automatic pulse_after(input int gap);
        tick(last_rise + gap - cyc);
        heart_pulse = 1'b1;
        if (cyc < MAXCYC) pin_rise[cyc] = 1'b1;
        last_rise = cyc;
        tick(3);
        heart_pulse = 1'b0;
    endtask

    int n0, l0, s0, keep;

    initial begin
        #1 rst_n = 1'b0;
        tick(5);
        check("reset bpm", int'(bpm), 0);
        check("reset digits", int'({hundreds, tens, ones}), 0);
        check("reset flags", int'({bpm_valid, led, buzzer, alarm_low, alarm_high, no_signal}), 0);
        rst_n = 1'b1;
        tick(10);

        // steady 100-cycle period: 60 bpm
        last_rise = cyc;
        n0 = n_strobe; l0 = led_cnt;
        repeat (6) pulse_after(100);
        tick(20);
        check("p100 strobes", n_strobe - n0, 5);
        check("p100 bpm", int'(bpm), 60);
        check("p100 hundreds", int'(hundreds), 0);
        check("p100 tens", int'(tens), 6);
        check("p100 ones", int'(ones), 0);
        check("p100 flags", int'({alarm_low, alarm_high, no_signal}), 0);
        check("p100 led cycles", led_cnt - l0, 60);

        // switch to period 40
        s0 = seen_q.size();
        repeat (4) pulse_after(40);
        tick(20);
        check("p40 strobes", seen_q.size() - s0, 4);
        if (seen_q.size() - s0 == 4) begin
            check("p40 bpm 1", seen_q[s0], 70);
            check("p40 bpm 2", seen_q[s0+1], 85);
            check("p40 bpm 3", seen_q[s0+2], 109);
            check("p40 bpm 4", seen_q[s0+3], 150);
        end

        // settle at 100 again, then inject a glitch 10 cycles after a beat
        repeat (5) pulse_after(100);
        tick(20);
        check("resettle bpm", int'(bpm), 60);
        n0 = n_strobe; l0 = led_cnt;
        pulse_after(100);
        keep = last_rise;
        pulse_after(10);
        last_rise = keep;
        pulse_after(100);
        tick(20);
        check("glitch strobes", n_strobe - n0, 2);
        check("glitch bpm", int'(bpm), 60);
        check("glitch led cycles", led_cnt - l0, 20);

        // pulses stop: timeout
        n0 = n_strobe;
        tick(2100);
        check("timeout strobes", n_strobe - n0, 1);
        check("timeout no_signal", int'(no_signal), 1);
        check("timeout bpm", int'(bpm), 0);
        check("timeout digits", int'({hundreds, tens, ones}), 0);
        check("timeout buzzer", int'(buzzer), 1);
        mute = 1'b1;
        tick(1);
        check("muted buzzer", int'(buzzer), 0);
        mute = 1'b0;
        n0 = n_strobe;
        last_rise = cyc - 100;
        pulse_after(100);
        pulse_after(100);
        tick(20);
        check("recover strobes", n_strobe - n0, 1);
        check("recover bpm", int'(bpm), 60);
        check("recover no_signal", int'(no_signal), 0);

        // slow rate: alarm_low, clear, re-set
        repeat (5) pulse_after(200);
        tick(20);
        check("p200 bpm", int'(bpm), 30);
        check("p200 alarm_low", int'(alarm_low), 1);
        clear_alarm = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        tick(1);
        check("cleared alarm_low", int'(alarm_low), 0);
        pulse_after(200);
        tick(20);
        check("reset alarm_low", int'(alarm_low), 1);
        check("p200 bpm again", int'(bpm), 30);

        // fast rate: alarm_high
        repeat (5) pulse_after(25);
        tick(20);
        check("p25 bpm", int'(bpm), 240);
        check("p25 alarm_high", int'(alarm_high), 1);

        // saturation: 6000/20 = 300 -> 255
        repeat (5) pulse_after(20);
        tick(20);
        check("p20 bpm", int'(bpm), 255);
        check("p20 hundreds", int'(hundreds), 2);
        check("p20 tens", int'(tens), 5);
        check("p20 ones", int'(ones), 5);

        // reset 5 cycles after an accepted beat aborts the pending division
        pulse_after(20);
        tick(4);
        n0 = n_strobe;
        rst_n = 1'b0;
        #1;
        check("midreset outputs", int'({bpm, bpm_valid, hundreds, tens, ones, led,
                                        buzzer, alarm_low, alarm_high, no_signal}), 0);
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check("midreset strobes", n_strobe - n0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
